// File: rtl/msk_inv_mc_col_serial_pkg.sv
// Shared definitions for the masked byte-serial InvMixColumns column engine.
package msk_inv_mc_col_serial_pkg;

    localparam logic [7:0] XTIME_POLY = 8'h1b;

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_e;

    function automatic int byteW(input int n);
        return 8 * n;
    endfunction

    // Row r takes coefficient (k-r) mod 4 from {xe, xb, xd, x9} for input byte k.
    function automatic logic [1:0] coefIdx(input logic [1:0] k, input logic [1:0] r);
        return k - r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/msk_inv_mc_col_serial_MSKprodMCinv.sv
// Share-wise multiplier producing x9/xb/xd/xe of one interleaved shared byte.
module MSKprodMCinv
    import msk_inv_mc_col_serial_pkg::*;
#(
    parameter int d = 2
) (
    input  logic [8*d-1:0] sh_byte_i,
    output logic [8*d-1:0] sh_x9_o,
    output logic [8*d-1:0] sh_xb_o,
    output logic [8*d-1:0] sh_xd_o,
    output logic [8*d-1:0] sh_xe_o
);

    for (genvar s = 0; s < d; s++) begin : g_share
        logic [7:0] x, x2, x4, x8;
        logic [7:0] x9, xb, xd, xe;

        // Each share has its own cone; bit i of share s sits at index i*d+s.
        always_comb begin
            x = '0;
            for (int i = 0; i < 8; i++) begin
                x[i] = sh_byte_i[i*d+s];
            end
        end

        assign x2 = xtime(x);
        assign x4 = xtime(x2);
        assign x8 = xtime(x4);
        assign x9 = x8 ^ x;
        assign xb = x8 ^ x2 ^ x;
        assign xd = x8 ^ x4 ^ x;
        assign xe = x8 ^ x4 ^ x2;

        for (genvar i = 0; i < 8; i++) begin : g_bit
            assign sh_x9_o[i*d+s] = x9[i];
            assign sh_xb_o[i*d+s] = xb[i];
            assign sh_xd_o[i*d+s] = xd[i];
            assign sh_xe_o[i*d+s] = xe[i];
        end
    end

endmodule

// File: rtl/msk_inv_mc_col_serial.sv
// Masked byte-serial InvMixColumns column engine (decryption direction).
// Optional final-round bypass enabled by defining MSK_INV_MC_BYPASS_EN.
module msk_inv_mc_col_serial
    import msk_inv_mc_col_serial_pkg::*;
#(
    parameter int d = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8*d-1:0]  sh_byte_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [32*d-1:0] sh_col_out
`ifdef MSK_INV_MC_BYPASS_EN
    ,
    input  logic            bypass
`endif
);

    localparam int BW = byteW(d);

    state_e          state_q;
    logic [1:0]      cnt_q;
    logic [BW-1:0]   acc_q [4];
    logic [BW-1:0]   acc_d [4];
    logic [BW-1:0]   coef  [4];
    logic            in_ready_q;
    logic            out_valid_q;
    logic            accept;
    logic [BW-1:0]   x9, xb, xd, xe;

    MSKprodMCinv #(.d(d)) u_prod (
        .sh_byte_i (sh_byte_in),
        .sh_x9_o   (x9),
        .sh_xb_o   (xb),
        .sh_xd_o   (xd),
        .sh_xe_o   (xe)
    );

    assign accept = in_valid & in_ready_q;

`ifdef MSK_INV_MC_BYPASS_EN
    logic bypass_q;
    logic bypassEff;

    assign bypassEff = (cnt_q == 2'd0) ? bypass : bypass_q;
`endif

    // Byte 0 overwrites the accumulators, so no earlier column survives into this one.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            coef[r] = '0;
            unique case (coefIdx(cnt_q, 2'(r)))
                2'd0:    coef[r] = xe;
                2'd1:    coef[r] = xb;
                2'd2:    coef[r] = xd;
                default: coef[r] = x9;
            endcase
            acc_d[r] = (cnt_q == 2'd0) ? coef[r] : (acc_q[r] ^ coef[r]);
`ifdef MSK_INV_MC_BYPASS_EN
            if (bypassEff) begin
                if (2'(r) == cnt_q) begin
                    acc_d[r] = sh_byte_in;
                end else begin
                    acc_d[r] = (cnt_q == 2'd0) ? '0 : acc_q[r];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            cnt_q       <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                acc_q[r] <= '0;
            end
`ifdef MSK_INV_MC_BYPASS_EN
            bypass_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (accept) begin
                        for (int r = 0; r < 4; r++) begin
                            acc_q[r] <= acc_d[r];
                        end
                        cnt_q <= cnt_q + 2'd1;
`ifdef MSK_INV_MC_BYPASS_EN
                        bypass_q <= bypassEff;
`endif
                        if (cnt_q == 2'd3) begin
                            state_q     <= OUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q     <= ACCUM;
                        cnt_q       <= 2'd0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign sh_col_out = {acc_q[3], acc_q[2], acc_q[1], acc_q[0]};

endmodule

// File: tb/tb_msk_inv_mc_col_serial.sv
// Directed bench for msk_inv_mc_col_serial (d=2); bypass section needs MSK_INV_MC_BYPASS_EN.
module tb_msk_inv_mc_col_serial;

    localparam int D = 2;

    typedef struct packed {
        logic [31:0] inCol;
        logic [31:0] expCol;
        logic        masked;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [8*D-1:0]  sh_byte_in;
    logic          out_valid;
    logic          out_ready;
    logic [32*D-1:0] sh_col_out;
`ifdef MSK_INV_MC_BYPASS_EN
    logic          bypass;
    logic          bypassSel;
`endif

    int checks = 0;
    int errors = 0;

    vec_t        vecs [5];
    logic [31:0] mask;
    logic [63:0] got;
    logic [63:0] snap;

    msk_inv_mc_col_serial #(.d(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sh_byte_in (sh_byte_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sh_col_out (sh_col_out)
`ifdef MSK_INV_MC_BYPASS_EN
        ,
        .bypass     (bypass)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] packShares(input logic [7:0] s0, input logic [7:0] s1);
        logic [15:0] p;
        for (int i = 0; i < 8; i++) begin
            p[i*2]   = s0[i];
            p[i*2+1] = s1[i];
        end
        return p;
    endfunction

    function automatic logic [31:0] shareCol(input logic [63:0] c, input int j);
        logic [31:0] o;
        logic [15:0] row;
        for (int r = 0; r < 4; r++) begin
            row = c[16*r +: 16];
            for (int i = 0; i < 8; i++) begin
                o[8*r+i] = row[i*2+j];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] aa;
        logic [7:0] p;
        aa = a;
        p  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Reference InvMixColumns on an unshared column, byte k at [8k+:8].
    function automatic logic [31:0] invMc(input logic [31:0] c);
        logic [7:0]  cf [4];
        logic [31:0] o;
        cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                o[8*r +: 8] = o[8*r +: 8] ^ gfMul(cf[(k - r + 4) % 4], c[8*k +: 8]);
            end
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actVal, input logic [63:0] expVal);
        checks++;
        if (actVal !== expVal) begin
            errors++;
            $display("[TB] FAIL %s: got %h, wanted %h", name, actVal, expVal);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] col, input logic [31:0] msk, input int nBytes);
        int waitCnt;
        for (int k = 0; k < nBytes; k++) begin
            in_valid   = 1'b1;
            sh_byte_in = packShares(msk[8*k +: 8], col[8*k +: 8] ^ msk[8*k +: 8]);
`ifdef MSK_INV_MC_BYPASS_EN
            bypass = (k == 0) ? bypassSel : 1'b0;
`endif
            waitCnt = 0;
            while (!in_ready && waitCnt < 50) begin
                @(posedge clk); #1;
                waitCnt++;
            end
            if (waitCnt >= 50) checkOutput("inReadyTimeout", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            if (nBytes == 4 && k == 2) checkOutput("outValidEarly", 64'(out_valid), 64'd0);
            if (nBytes == 4 && k == 3) checkOutput("outValidLatency", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
`ifdef MSK_INV_MC_BYPASS_EN
        bypass = 1'b0;
`endif
    endtask

    task automatic collectColumn(output logic [63:0] col);
        int waitCnt;
        waitCnt = 0;
        while (!out_valid && waitCnt < 50) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (waitCnt >= 50) checkOutput("outValidTimeout", 64'(out_valid), 64'd1);
        col = sh_col_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("outValidDrop", 64'(out_valid), 64'd0);
        checkOutput("inReadyReturn", 64'(in_ready), 64'd1);
    endtask

    initial begin
        vecs[0] = '{inCol: 32'hbca14d8e, expCol: 32'h455313db, masked: 1'b0};
        vecs[1] = '{inCol: 32'h9d58dc9f, expCol: 32'h5c220af2, masked: 1'b1};
        vecs[2] = '{inCol: 32'h01010101, expCol: 32'h01010101, masked: 1'b0};
        vecs[3] = '{inCol: 32'hc6c6c6c6, expCol: 32'hc6c6c6c6, masked: 1'b1};
        vecs[4] = '{inCol: 32'hf8bd7e4d, expCol: 32'h4c31262d, masked: 1'b1};

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        sh_byte_in = '0;
`ifdef MSK_INV_MC_BYPASS_EN
        bypass     = 1'b0;
        bypassSel  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("resetInReady", 64'(in_ready), 64'd1);
        checkOutput("resetOutValid", 64'(out_valid), 64'd0);
        checkOutput("resetAcc", sh_col_out, 64'd0);

        for (int i = 0; i < 5; i++) begin
            mask = vecs[i].masked ? $urandom : vecs[i].inCol;
            applyStimulus(vecs[i].inCol, mask, 4);
            collectColumn(got);
            checkOutput($sformatf("vec%0d_col", i),
                        64'(shareCol(got, 0) ^ shareCol(got, 1)), 64'(vecs[i].expCol));
            checkOutput($sformatf("vec%0d_share0", i), 64'(shareCol(got, 0)), 64'(invMc(mask)));
            checkOutput($sformatf("vec%0d_share1", i), 64'(shareCol(got, 1)),
                        64'(invMc(vecs[i].inCol ^ mask)));
        end

        // Backpressure: column waits while new bytes are offered and must be ignored.
        mask = $urandom;
        applyStimulus(32'h9d58dc9f, mask, 4);
        snap = sh_col_out;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            sh_byte_in = 16'($urandom);
            @(posedge clk); #1;
            checkOutput($sformatf("bpInReady%0d", c), 64'(in_ready), 64'd0);
            checkOutput($sformatf("bpOutValid%0d", c), 64'(out_valid), 64'd1);
            checkOutput($sformatf("bpStable%0d", c), sh_col_out, snap);
        end
        in_valid = 1'b0;
        collectColumn(got);
        checkOutput("bpCol", 64'(shareCol(got, 0) ^ shareCol(got, 1)), 64'h5c220af2);
        mask = $urandom;
        applyStimulus(32'hbca14d8e, mask, 4);
        collectColumn(got);
        checkOutput("bpNextCol", 64'(shareCol(got, 0) ^ shareCol(got, 1)), 64'h455313db);

        // Reset after two bytes discards the partial column.
        mask = $urandom;
        applyStimulus(32'h12345678, mask, 2);
        rst = 1'b1;
        checkOutput("midRstOutValidPre", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midRstOutValid", 64'(out_valid), 64'd0);
        checkOutput("midRstInReady", 64'(in_ready), 64'd1);
        checkOutput("midRstAcc", sh_col_out, 64'd0);
        mask = $urandom;
        applyStimulus(32'hf8bd7e4d, mask, 4);
        collectColumn(got);
        checkOutput("midRstCol", 64'(shareCol(got, 0) ^ shareCol(got, 1)), 64'h4c31262d);

`ifdef MSK_INV_MC_BYPASS_EN
        bypassSel = 1'b1;
        mask = $urandom;
        applyStimulus(32'hbca14d8e, mask, 4);
        collectColumn(got);
        checkOutput("bypassOn", 64'(shareCol(got, 0) ^ shareCol(got, 1)), 64'hbca14d8e);
        checkOutput("bypassShare0", 64'(shareCol(got, 0)), 64'(mask));
        bypassSel = 1'b0;
        mask = $urandom;
        applyStimulus(32'hbca14d8e, mask, 4);
        collectColumn(got);
        checkOutput("bypassOff", 64'(shareCol(got, 0) ^ shareCol(got, 1)), 64'h455313db);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
